// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller signal bundle: PC register port, instruction-memory handshake,
// datapath completion/redirect inputs and trap reporting.
interface pc_fetch_ctrl_if;
  logic [31:0] pc_q;
  logic        pc_ena;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        ex_done;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exc_req;
  logic        trap;
  logic [31:0] epc;
  logic [1:0]  exc_cause;

  modport master (
    input  pc_q, imem_ack, imem_rdata, ex_done, redirect, redirect_pc, exc_req,
    output pc_ena, pc_next, imem_req, imem_addr, instr, instr_valid, trap, epc, exc_cause
  );

  modport slave (
    output pc_q, imem_ack, imem_rdata, ex_done, redirect, redirect_pc, exc_req,
    input  pc_ena, pc_next, imem_req, imem_addr, instr, instr_valid, trap, epc, exc_cause
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Multi-cycle fetch/PC sequencer: INIT -> FETCH <-> EXEC, with redirect, datapath
// exception, misaligned-target and fetch-timeout traps recorded into epc/exc_cause.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               rst,
  pc_fetch_ctrl_if.master    fc
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   epc_q, epc_d;
  logic [1:0]    cause_q, cause_d;

  logic          pc_ena;
  logic [31:0]   pc_next;
  logic          imem_req;
  logic          instr_valid;
  logic          trap;
  logic [31:0]   pc_seq;

  assign pc_seq = fc.pc_q + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      wait_q  <= '0;
      instr_q <= '0;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      instr_q <= instr_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    instr_d     = instr_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    pc_ena      = 1'b0;
    pc_next     = pc_seq;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    trap        = 1'b0;

    unique case (state_q)
      S_INIT: begin
        pc_ena  = 1'b1;
        pc_next = RESET_PC;
        wait_d  = '0;
        state_d = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (fc.imem_ack) begin
          instr_d = fc.imem_rdata;
          wait_d  = '0;
          state_d = S_EXEC;
        end else if (wait_q == WAIT_LAST) begin
          // Timeout retries the fetch at the vector; the counter restarts for it.
          trap    = 1'b1;
          pc_ena  = 1'b1;
          pc_next = EXC_VECTOR;
          epc_d   = fc.pc_q;
          cause_d = 2'd3;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_EXEC: begin
        instr_valid = 1'b1;
        if (fc.ex_done) begin
          pc_ena  = 1'b1;
          wait_d  = '0;
          state_d = S_FETCH;
          if (fc.exc_req) begin
            trap    = 1'b1;
            pc_next = EXC_VECTOR;
            epc_d   = fc.pc_q;
            cause_d = 2'd1;
          end else if (fc.redirect && (fc.redirect_pc[1:0] != 2'b00)) begin
            trap    = 1'b1;
            pc_next = EXC_VECTOR;
            epc_d   = fc.pc_q;
            cause_d = 2'd2;
          end else if (fc.redirect) begin
            pc_next = fc.redirect_pc;
          end
        end
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  assign fc.pc_ena      = pc_ena;
  assign fc.pc_next     = pc_next;
  assign fc.imem_req    = imem_req;
  assign fc.imem_addr   = fc.pc_q;
  assign fc.instr       = instr_q;
  assign fc.instr_valid = instr_valid;
  assign fc.trap        = trap;
  assign fc.epc         = epc_q;
  assign fc.exc_cause   = cause_q;

endmodule
